// File: rtl/reg_arb_pkg.sv
// Purpose: shared types, defaults and helpers for the round-robin register write arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package reg_arb_pkg;

  // Arbiter FSM. LOCKED is only entered when REG_ARB_LOCK_EN is defined.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 4;

  // Width of a requester index. It is never narrower than one bit.
  function automatic int owner_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Purpose: combinational round-robin picker; first set bit of elig scanning ptr, ptr+1, ... mod NREQ.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller masks elig to exclude requesters that must wait.
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int PW   = owner_w(NREQ)
) (
  input  logic [NREQ-1:0] elig,
  input  logic [PW-1:0]   ptr,
  output logic            any,
  output logic [PW-1:0]   winner
);

  logic [PW-1:0] idx;

  // Scan from the farthest offset down to ptr so the closest eligible index is the last one written.
  always_comb begin
    idx    = '0;
    winner = '0;
    any    = |elig;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % NREQ);
      if (elig[idx]) begin
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Purpose: grants one write per cycle into a shared WIDTH-bit register, round-robin over NREQ requesters.
//   Optional burst lock lets a winner keep exclusive access; it is enabled by defining REG_ARB_LOCK_EN.
// Latency: 1 cycle, from req sampled at an edge to q/ack updated after that edge.
// Backpressure: losers wait with no side effects. A requester is masked during its own ack cycle.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  input  logic [NREQ-1:0]         lock,
  output logic [NREQ-1:0]         ack,
  output logic [WIDTH-1:0]        q,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    valid
);

  localparam int PW = owner_w(NREQ);

  logic [NREQ-1:0]  ack_q,   ack_d;
  logic [WIDTH-1:0] q_q,     q_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [PW-1:0]    ptr_q,   ptr_d;
  logic             valid_q, valid_d;

  logic [NREQ-1:0]  elig;
  logic             pick_any;
  logic [PW-1:0]    pick_idx;

`ifdef REG_ARB_LOCK_EN
  arb_state_e       state_q, state_d;
  logic [NREQ-1:0]  owner_oh;
  logic             lock_hold;

  // The lock is kept only while the current owner still asserts its lock bit.
  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    lock_hold         = (state_q == LOCKED) && lock[owner_q];
  end

  // Eligibility: mask each requester in its own ack cycle, and admit only the owner while the lock holds.
  always_comb begin
    elig = req & ~ack_q;
    if (lock_hold) begin
      elig = elig & owner_oh;
    end
  end

  // FSM next state. A grant taken with its lock bit set (re)enters LOCKED.
  always_comb begin
    state_d = IDLE;
    if (pick_any) begin
      state_d = lock[pick_idx] ? LOCKED : IDLE;
    end else if (lock_hold) begin
      state_d = LOCKED;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock;

  // Eligibility: mask each requester in its own ack cycle, so a held req is not counted twice.
  always_comb begin
    elig = req & ~ack_q;
  end
`endif

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .elig   (elig),
    .ptr    (ptr_q),
    .any    (pick_any),
    .winner (pick_idx)
  );

  // Grant datapath: load the winner's data, pulse its ack and advance the pointer past it.
  always_comb begin
    q_d     = q_q;
    ack_d   = '0;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    if (pick_any) begin
      q_d             = wdata[int'(pick_idx)*WIDTH +: WIDTH];
      ack_d[pick_idx] = 1'b1;
      owner_d         = pick_idx;
      valid_d         = 1'b1;
      if (pick_idx == PW'(NREQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = pick_idx + PW'(1);
      end
    end
  end

  // Output and pointer registers. Reset overrides any grant in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q     <= '0;
      ack_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      ack_q   <= ack_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
    end
  end

  assign ack   = ack_q;
  assign q     = q_q;
  assign owner = owner_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Purpose: randomized and directed bench for reg_write_arbiter, checked every cycle against a queue-free scan model.
// Latency: the model updates on posedge; outputs are compared on negedge.
// Backpressure: n/a.
module tb_reg_write_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] lock = '0;
  logic [N*W-1:0] wdata = '0;
  logic [N-1:0] ack;
  logic [W-1:0] q;
  logic [1:0]   owner;
  logic         valid;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_write_arbiter #(.NREQ(N), .WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .wdata (wdata),
    .lock  (lock),
    .ack   (ack),
    .q     (q),
    .owner (owner),
    .valid (valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: scan requesters in priority order starting at ptr, and take the first one that may write.
  logic [N-1:0] m_ack;
  logic [W-1:0] m_q;
  int           m_owner;
  int           m_ptr;
  bit           m_valid;
`ifdef REG_ARB_LOCK_EN
  bit           m_locked;
`endif

  always @(posedge clk) begin
    int  win;
    int  idx;
    bit  cand;
`ifdef REG_ARB_LOCK_EN
    bit  nxt_locked;
    bit  holding;
`endif
    if (rst) begin
      m_ack   = '0;
      m_q     = '0;
      m_owner = 0;
      m_ptr   = 0;
      m_valid = 0;
`ifdef REG_ARB_LOCK_EN
      m_locked = 0;
`endif
    end else begin
      win = -1;
`ifdef REG_ARB_LOCK_EN
      holding = m_locked && lock[m_owner];
`endif
      for (int k = 0; k < N; k++) begin
        idx  = (m_ptr + k) % N;
        cand = req[idx] && !m_ack[idx];
`ifdef REG_ARB_LOCK_EN
        if (holding && idx != m_owner) cand = 0;
`endif
        if (cand && win < 0) win = idx;
      end
`ifdef REG_ARB_LOCK_EN
      nxt_locked = (win >= 0) ? lock[win] : holding;
      m_locked   = nxt_locked;
`endif
      m_ack = '0;
      if (win >= 0) begin
        m_ack[win] = 1'b1;
        m_q        = wdata[win*W +: W];
        m_owner    = win;
        m_ptr      = (win + 1) % N;
        m_valid    = 1;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    check("ack", 32'(ack), 32'(m_ack));
    check("q", 32'(q), 32'(m_q));
    check("owner", 32'(owner), 32'(m_owner));
    check("valid", 32'(valid), 32'(m_valid));
  end

  initial begin
    // Requester data 1..4, and all requesters active while reset is held.
    rst   = 1'b1;
    req   = 4'b1111;
    wdata = 16'h4321;
    repeat (2) begin
      @(negedge clk);
      check("rst_ack", 32'(ack), 32'h0);
      check("rst_q", 32'(q), 32'h0);
      check("rst_valid", 32'(valid), 32'h0);
      check("rst_owner", 32'(owner), 32'h0);
    end
    rst = 1'b0;

    // Round robin over four simultaneous requests.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rr_ack", 32'(ack), 32'(1 << i));
      check("rr_q", 32'(q), 32'(i + 1));
    end

    // Wrap-around: the pointer is back at 0 after the grant to requester 3.
    req = 4'b0101;
    @(negedge clk);
    check("wrap_ack0", 32'(ack), 32'h1);
    check("wrap_q0", 32'(q), 32'h1);
    @(negedge clk);
    check("wrap_ack2", 32'(ack), 32'h4);
    check("wrap_q2", 32'(q), 32'h3);

    // A single held requester is acked every second cycle.
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst   = 1'b0;
    req   = 4'b0001;
    wdata = 16'h000A;
    @(negedge clk);
    check("single_ack", 32'(ack), 32'h1);
    check("single_q", 32'(q), 32'hA);
    check("single_owner", 32'(owner), 32'h0);
    @(negedge clk);
    check("single_gap", 32'(ack), 32'h0);
    @(negedge clk);
    check("single_again", 32'(ack), 32'h1);

    // A reset pulse replaces a grant, and the pointer restarts at 0.
    req   = 4'b1111;
    wdata = 16'h4321;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_ack", 32'(ack), 32'h0);
    check("rstmid_q", 32'(q), 32'h0);
    check("rstmid_valid", 32'(valid), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_next_ack", 32'(ack), 32'h1);
    check("rstmid_next_owner", 32'(owner), 32'h0);

`ifdef REG_ARB_LOCK_EN
    // Burst lock: move the pointer to 1 first, then lock requester 1 for six cycles.
    begin
      logic [N-1:0] exp_ack [8];
      exp_ack = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0001};
      rst = 1'b1;
      req = '0;
      @(negedge clk);
      rst = 1'b0;
      req = 4'b0001;
      @(negedge clk);
      req  = 4'b0111;
      lock = 4'b0010;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        check("lock_ack", 32'(ack), 32'(exp_ack[i]));
        if (i == 5) lock = '0;
      end
    end
`endif

    // Randomized traffic with occasional reset pulses. Requests are often held to mimic the requester contract.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) != 0) begin
        req = req | N'($urandom);
        req = req & ~ack;
        req = req | (N'($urandom) & ack);
      end else begin
        req = N'($urandom);
      end
      wdata = 16'($urandom);
      rst   = ($urandom_range(0, 39) == 0);
      lock  = ($urandom_range(0, 2) == 0) ? N'($urandom) : lock;
    end
    rst = 1'b0;
    req = '0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
